// File: rtl/alu_uart_pkg.sv
// Shared UART definitions for the ALU result transmitter and its matching receiver.
// Frame length accounts for the optional parity bit (ALU_RESULT_TX_PARITY_EN).
package alu_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  // 50 MHz system clock at 9600 baud
  localparam int CLKS_PER_BIT_DEFAULT = 5208;

`ifdef ALU_RESULT_TX_PARITY_EN
  localparam int PARITY_SLOTS = 1;
`else
  localparam int PARITY_SLOTS = 0;
`endif

  function automatic int frame_clks(input int bits_data, input int clks_per_bit);
    return (2 + bits_data + PARITY_SLOTS) * clks_per_bit;
  endfunction

  localparam int FRAME_CLKS_DEFAULT = frame_clks(8, CLKS_PER_BIT_DEFAULT);

endpackage

// File: rtl/alu_result_tx_if.sv
// Valid/ready word input plus serial line and frame-done outputs of the result transmitter.
interface alu_result_tx_if #(
  parameter int BITS_DATA = 8
);
  logic                 valid;
  logic [BITS_DATA-1:0] data;
  logic                 ready;
  logic                 tx;
  logic                 done;

  modport master (output valid, data, input ready, tx, done);
  modport slave  (input valid, data, output ready, tx, done);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and ticks on the terminal count.
module uart_baud_tick
  import alu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic clear,
  output logic tick
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg <= '0;
    end else if (clear || count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // A cleared timer never ticks, so the first bit period after IDLE is full length
  assign tick = !clear && (count_reg == LAST);
endmodule

// File: rtl/alu_result_tx.sv
// UART-style serial transmitter for ALU results: start, LSB-first data, stop.
// Define ALU_RESULT_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module alu_result_tx
  import alu_uart_pkg::*;
#(
  parameter int BITS_DATA    = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic           clk,
  input  logic           i_rst_n,
  alu_result_tx_if.slave bus
);
  localparam int BIT_W = (BITS_DATA > 1) ? $clog2(BITS_DATA) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_DATA - 1);

  uart_state_t          state_reg, state_next;
  logic [BITS_DATA-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]     bit_reg, bit_next;
  logic                 tx_reg, tx_next;
  logic                 ready_reg, ready_next;
  logic                 done_reg, done_next;
  logic                 tick;
  logic                 accept;

  assign accept = bus.valid && ready_reg;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk    (clk),
    .i_rst_n(i_rst_n),
    .clear  (state_reg == ST_IDLE),
    .tick   (tick)
  );

`ifdef ALU_RESULT_TX_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      parity_reg <= 1'b0;
    end else if (accept) begin
      parity_reg <= ^bus.data;
    end
  end
`endif

  // State register; the line outputs are registered here too so tx never comes from logic
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      bit_reg   <= '0;
      tx_reg    <= 1'b1;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
      tx_reg    <= tx_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_START;
          shift_next = bus.data;
          bit_next   = '0;
        end
      end
      ST_START: begin
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_reg == LAST_BIT) begin
`ifdef ALU_RESULT_TX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = shift_reg >> 1;
          end
        end
      end
`ifdef ALU_RESULT_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so the flops show it one cycle later
  always_comb begin
    tx_next    = 1'b1;
    ready_next = (state_next == ST_IDLE);
    done_next  = (state_reg == ST_STOP) && (state_next == ST_IDLE);
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
`ifdef ALU_RESULT_TX_PARITY_EN
      ST_PARITY: tx_next = parity_reg;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  assign bus.ready = ready_reg;
  assign bus.tx    = tx_reg;
  assign bus.done  = done_reg;
endmodule
